// File: rtl/net_terminal_adapter.sv
// -----------------------------------------------------------------------------
// net_terminal_adapter
//
// Client-side endpoint for one port of the 8-port ring network.
//   TX path: client (dest, payload) requests are stamped with this terminal's
//            id as src and a rolling sequence number as opaque. They are then
//            held in a 2-entry queue for injection into the network in_* port.
//   RX path: messages ejected from the network out_* port are held in a
//            2-entry queue and unpacked to the client.
//
// Network message layout (c_net_msg_nbits bits, MSB first):
//   {dest[s], src[s], opaque[o], payload[p]}
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   tx_val/tx_rdy         client send request handshake
//   tx_dest, tx_payload   client send request fields
//   inj_val/inj_rdy       handshake to network in_val/in_rdy[port]
//   inj_msg               message to network in_msg[port]
//   ej_val/ej_rdy         handshake from network out_val/out_rdy[port]
//   ej_msg                message from network out_msg[port]
//   rx_val/rx_rdy         received-message handshake to the client
//   rx_src, rx_opaque,    fields of the head RX message
//   rx_payload
//   tx_count, rx_count    injected / delivered message counters (wrap 2^16)
//   dest_err              sticky misrouted-message flag
//
// Optional feature macro: NET_TERMINAL_DEST_CHECK_EN
//   Defined:   ejected messages whose dest differs from p_terminal_id are
//              accepted but dropped, and dest_err is set until reset.
//   Undefined: every ejected message is delivered; dest_err is tied to 0.
//
// Handshake rule for every interface: a transfer happens in a cycle where
// val and rdy are both high at the rising clock edge. The val/rdy outputs
// come only from queue occupancy registers, never combinationally from the
// same interface's inputs.
// -----------------------------------------------------------------------------
module net_terminal_adapter #(
    parameter int p_payload_nbits = 32,
    parameter int p_opaque_nbits  = 3,
    parameter int p_srcdest_nbits = 3,
    parameter int p_terminal_id   = 0,
    parameter int c_net_msg_nbits = p_payload_nbits + p_opaque_nbits + 2*p_srcdest_nbits
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_val,
    output logic                       tx_rdy,
    input  logic [p_srcdest_nbits-1:0] tx_dest,
    input  logic [p_payload_nbits-1:0] tx_payload,
    output logic                       inj_val,
    input  logic                       inj_rdy,
    output logic [c_net_msg_nbits-1:0] inj_msg,
    input  logic                       ej_val,
    output logic                       ej_rdy,
    input  logic [c_net_msg_nbits-1:0] ej_msg,
    output logic                       rx_val,
    input  logic                       rx_rdy,
    output logic [p_srcdest_nbits-1:0] rx_src,
    output logic [p_opaque_nbits-1:0]  rx_opaque,
    output logic [p_payload_nbits-1:0] rx_payload,
    output logic [15:0]                tx_count,
    output logic [15:0]                rx_count,
    output logic                       dest_err
);

    localparam int c_p = p_payload_nbits;
    localparam int c_o = p_opaque_nbits;
    localparam int c_s = p_srcdest_nbits;
    localparam int c_m = c_net_msg_nbits;
    // RX entries drop the dest field: it is this terminal by construction.
    localparam int c_r = c_s + c_o + c_p;

    localparam logic [c_s-1:0] c_my_id = c_s'(p_terminal_id);

    // -------------------------------------------------------------------------
    // TX queue: 2 entries, head pointer plus occupancy count.
    // -------------------------------------------------------------------------
    logic [c_m-1:0] r_tx_mem [2];
    logic           r_tx_head;
    logic [1:0]     r_tx_cnt;
    logic [c_o-1:0] r_seq;
    logic [15:0]    r_tx_count;

    logic           w_tx_enq;
    logic           w_tx_deq;
    logic           w_tx_tail;
    logic [c_m-1:0] w_tx_entry;

    assign tx_rdy     = (r_tx_cnt != 2'd2);
    assign inj_val    = (r_tx_cnt != 2'd0);
    assign inj_msg    = r_tx_mem[r_tx_head];
    assign w_tx_enq   = tx_val && tx_rdy;
    assign w_tx_deq   = inj_val && inj_rdy;
    // Tail slot is head offset by occupancy; only used when not full.
    assign w_tx_tail  = r_tx_head ^ r_tx_cnt[0];
    assign w_tx_entry = {tx_dest, c_my_id, r_seq, tx_payload};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_head  <= 1'b0;
            r_tx_cnt   <= 2'd0;
            r_seq      <= '0;
            r_tx_count <= 16'd0;
        end else begin
            r_tx_cnt <= r_tx_cnt + {1'b0, w_tx_enq} - {1'b0, w_tx_deq};
            if (w_tx_deq) begin
                r_tx_head  <= ~r_tx_head;
                r_tx_count <= r_tx_count + 16'd1;
            end
            if (w_tx_enq) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_tx_enq) begin
            r_tx_mem[w_tx_tail] <= w_tx_entry;
        end
    end

    // -------------------------------------------------------------------------
    // RX queue: same structure as TX.
    // -------------------------------------------------------------------------
    logic [c_r-1:0] r_rx_mem [2];
    logic           r_rx_head;
    logic [1:0]     r_rx_cnt;
    logic [15:0]    r_rx_count;

    logic           w_ej_xfer;
    logic           w_rx_enq;
    logic           w_rx_deq;
    logic           w_rx_tail;
    logic [c_s-1:0] w_ej_dest;
    logic [c_r-1:0] w_rx_head_entry;

    assign ej_rdy          = (r_rx_cnt != 2'd2);
    assign rx_val          = (r_rx_cnt != 2'd0);
    assign w_ej_xfer       = ej_val && ej_rdy;
    assign w_rx_deq        = rx_val && rx_rdy;
    assign w_rx_tail       = r_rx_head ^ r_rx_cnt[0];
    assign w_ej_dest       = ej_msg[c_m-1 -: c_s];
    assign w_rx_head_entry = r_rx_mem[r_rx_head];

    assign rx_src     = w_rx_head_entry[c_r-1 -: c_s];
    assign rx_opaque  = w_rx_head_entry[c_p +: c_o];
    assign rx_payload = w_rx_head_entry[c_p-1:0];

`ifdef NET_TERMINAL_DEST_CHECK_EN
    logic r_dest_err;

    // Misrouted messages still complete the ej handshake but are dropped.
    assign w_rx_enq = w_ej_xfer && (w_ej_dest == c_my_id);
    assign dest_err = r_dest_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dest_err <= 1'b0;
        end else if (w_ej_xfer && (w_ej_dest != c_my_id)) begin
            r_dest_err <= 1'b1;
        end
    end
`else
    logic w_unused_dest;

    assign w_rx_enq      = w_ej_xfer;
    assign dest_err      = 1'b0;
    assign w_unused_dest = ^w_ej_dest;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_head  <= 1'b0;
            r_rx_cnt   <= 2'd0;
            r_rx_count <= 16'd0;
        end else begin
            r_rx_cnt <= r_rx_cnt + {1'b0, w_rx_enq} - {1'b0, w_rx_deq};
            if (w_rx_deq) begin
                r_rx_head  <= ~r_rx_head;
                r_rx_count <= r_rx_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_enq) begin
            r_rx_mem[w_rx_tail] <= ej_msg[c_r-1:0];
        end
    end

    assign tx_count = r_tx_count;
    assign rx_count = r_rx_count;

endmodule
